// File: rtl/ff_d_pkg.sv
// Shared types and helpers for the FF_D family of register-chain blocks.
// tap_w() sizes tap selects and occupancy counters; stage_t is the default-width stage record.
package ff_d_pkg;

    localparam int unsigned DwDefault = 4;

    function automatic int unsigned tap_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic [DwDefault-1:0] data;
        logic                 valid;
    } stage_t;

endpackage

// File: rtl/ff_d_tapped_delay_line_stage.sv
// One data+valid register stage with stall, flush and selectable capture edge.
module ff_d_stage #(
    parameter int unsigned DW       = 4,
    parameter int unsigned NEG_EDGE = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [DW-1:0] data_in,
    input  logic          valid_in,
    output logic [DW-1:0] data_out,
    output logic          valid_out
);

    logic [DW-1:0] data_d, data_q;
    logic          valid_d, valid_q;

    // Flush only clears the qualifier; the data word is left in place.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = data_in;
            valid_d = valid_in;
        end
    end

    if (NEG_EDGE != 0) begin : g_neg
        always_ff @(negedge clock or negedge reset) begin
            if (!reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/ff_d_tapped_delay_line.sv
// Programmable-latency delay line: N-stage register chain with a run-time tap mux,
// saturating tap select and a valid-entry occupancy counter.
module ff_d_tapped_delay_line
    import ff_d_pkg::*;
#(
    parameter int unsigned N        = 10,
    parameter int unsigned DW       = 4,
    parameter int unsigned NEG_EDGE = 0,
    localparam int unsigned TW      = tap_w(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic [TW-1:0] tap_sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [TW-1:0] occupancy,
    output logic          tap_err
);

    logic [DW-1:0] stage_data  [N];
    logic          stage_valid [N];
    logic [TW-1:0] occ_d, occ_q;

    for (genvar i = 0; i < N; i++) begin : g_stage
        ff_d_stage #(
            .DW       (DW),
            .NEG_EDGE (NEG_EDGE)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .en        (en),
            .flush     (flush),
            .data_in   ((i == 0) ? din : stage_data[(i == 0) ? 0 : i - 1]),
            .valid_in  ((i == 0) ? din_valid : stage_valid[(i == 0) ? 0 : i - 1]),
            .data_out  (stage_data[i]),
            .valid_out (stage_valid[i])
        );
    end

    // Tap 0 is a zero-latency bypass; out-of-range selects saturate to the last stage.
    always_comb begin
        dout       = din;
        dout_valid = din_valid;
        tap_err    = 1'b0;
        if (tap_sel > TW'(N)) begin
            dout       = stage_data[N-1];
            dout_valid = stage_valid[N-1];
            tap_err    = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (tap_sel == TW'(k)) begin
                    dout       = stage_data[k-1];
                    dout_valid = stage_valid[k-1];
                end
            end
        end
    end

    // Tracks popcount of the valid bits without an adder tree: one in, one out per shift.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + TW'(din_valid) - TW'(stage_valid[N-1]);
        end
    end

    if (NEG_EDGE != 0) begin : g_occ_neg
        always_ff @(negedge clock or negedge reset) begin
            if (!reset) occ_q <= '0;
            else        occ_q <= occ_d;
        end
    end else begin : g_occ_pos
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) occ_q <= '0;
            else        occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
